// File: rtl/rom_fetch_ctrl.sv
// Program-ROM fetch controller: owns the PC, latches ROM data into an
// instruction register and offers it downstream over a valid/ready handshake.
module rom_fetch_ctrl #(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 8,
   parameter int START_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              halt,
   input  logic              jmp_en,
   input  logic [ADDR_W-1:0] jmp_addr,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic              busy,
   output logic              wrap
);

   localparam logic [ADDR_W-1:0] LP_START = ADDR_W'(START_ADDR);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_pc;
   logic [DATA_W-1:0]   r_instr;
   logic                r_instr_valid;
   logic                r_wrap;
   logic                r_jmp_pend;
   logic [ADDR_W-1:0]   r_jmp_tgt;
   logic                r_halt_pend;

   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   w_pc_nxt;
   logic [DATA_W-1:0]   w_instr_nxt;
   logic                w_valid_nxt;
   logic                w_wrap_nxt;
   logic                w_jmp_pend_nxt;
   logic [ADDR_W-1:0]   w_jmp_tgt_nxt;
   logic                w_halt_pend_nxt;
   logic                w_hs;
   logic [ADDR_W-1:0]   w_pc_inc;

   assign w_hs     = (r_state == S_WAIT) && r_instr_valid && instr_ready;
   assign w_pc_inc = r_pc + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_pc          <= LP_START;
         r_instr       <= '0;
         r_instr_valid <= 1'b0;
         r_wrap        <= 1'b0;
         r_jmp_pend    <= 1'b0;
         r_jmp_tgt     <= '0;
         r_halt_pend   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_instr       <= w_instr_nxt;
         r_instr_valid <= w_valid_nxt;
         r_wrap        <= w_wrap_nxt;
         r_jmp_pend    <= w_jmp_pend_nxt;
         r_jmp_tgt     <= w_jmp_tgt_nxt;
         r_halt_pend   <= w_halt_pend_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_instr_nxt     = r_instr;
      w_valid_nxt     = r_instr_valid;
      w_wrap_nxt      = 1'b0;
      w_jmp_pend_nxt  = r_jmp_pend;
      w_jmp_tgt_nxt   = r_jmp_tgt;
      w_halt_pend_nxt = r_halt_pend;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_FETCH;
            end
         end

         S_FETCH: begin
            w_instr_nxt = rom_data;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_WAIT;
            if (jmp_en) begin
               w_jmp_pend_nxt = 1'b1;
               w_jmp_tgt_nxt  = jmp_addr;
            end
            if (halt) begin
               w_halt_pend_nxt = 1'b1;
            end
         end

         S_WAIT: begin
            if (w_hs) begin
               w_valid_nxt    = 1'b0;
               w_jmp_pend_nxt = 1'b0;
               // A same-cycle jump beats a pending one; only the plain
               // increment can signal a wrap.
               if (jmp_en) begin
                  w_pc_nxt = jmp_addr;
               end else if (r_jmp_pend) begin
                  w_pc_nxt = r_jmp_tgt;
               end else begin
                  w_pc_nxt   = w_pc_inc;
                  w_wrap_nxt = &r_pc;
               end
               if (halt || r_halt_pend) begin
                  w_state_nxt     = S_IDLE;
                  w_halt_pend_nxt = 1'b0;
               end else begin
                  w_state_nxt = S_FETCH;
               end
            end else begin
               if (jmp_en) begin
                  w_jmp_pend_nxt = 1'b1;
                  w_jmp_tgt_nxt  = jmp_addr;
               end
               if (halt) begin
                  w_halt_pend_nxt = 1'b1;
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign rom_addr    = r_pc;
   assign instr       = r_instr;
   assign instr_valid = r_instr_valid;
   assign busy        = (r_state != S_IDLE);
   assign wrap        = r_wrap;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Bench for rom_fetch_ctrl: ROM model returns {addr, ~addr}; a scoreboard
// checks every consumed instruction, and per-cycle vectors check control.
module tb_rom_fetch_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       halt;
   logic       jmp_en;
   logic [3:0] jmp_addr;
   logic [3:0] rom_addr;
   logic [7:0] rom_data;
   logic [7:0] instr;
   logic       instr_valid;
   logic       instr_ready;
   logic       busy;
   logic       wrap;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] mon_e;

   typedef struct {
      logic       start;
      logic       halt;
      logic       jen;
      logic [3:0] jaddr;
      logic       rdy;
      logic       e_valid;
      logic       e_busy;
      logic [3:0] e_addr;
      logic [7:0] e_instr;
   } vec_t;

   vec_t vt[22];

   rom_fetch_ctrl #(.ADDR_W(4), .DATA_W(8), .START_ADDR(0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .halt        (halt),
      .jmp_en      (jmp_en),
      .jmp_addr    (jmp_addr),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .busy        (busy),
      .wrap        (wrap)
   );

   assign rom_data = {rom_addr, ~rom_addr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(int s, int h, int j, int ja, int r,
                               int ev, int eb, int ea, int ei);
      vec_t v;
      v.start   = s[0];
      v.halt    = h[0];
      v.jen     = j[0];
      v.jaddr   = ja[3:0];
      v.rdy     = r[0];
      v.e_valid = ev[0];
      v.e_busy  = eb[0];
      v.e_addr  = ea[3:0];
      v.e_instr = ei[7:0];
      return v;
   endfunction

   task automatic drive(input logic s, input logic h, input logic j,
                        input logic [3:0] ja, input logic r);
      start       = s;
      halt        = h;
      jmp_en      = j;
      jmp_addr    = ja;
      instr_ready = r;
   endtask

   // Scoreboard: every handshake must consume the oldest expected instruction.
   always @(posedge clk) begin
      if (rst_n && instr_valid && instr_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL hs_unexpected got=%0h want=none", instr);
         end else begin
            mon_e = exp_q.pop_front();
            chk("hs_instr", 32'(instr), 32'(mon_e));
         end
      end
   end

   initial begin
      int wrap_cnt;
      logic [3:0] wrap_addr;

      vt[0]  = mk(1,0,0,0,1, 0,1,0,8'h00);
      vt[1]  = mk(0,0,0,0,1, 1,1,0,8'h0F);
      vt[2]  = mk(0,0,0,0,1, 0,1,1,8'h00);
      vt[3]  = mk(0,0,0,0,1, 1,1,1,8'h1E);
      vt[4]  = mk(0,0,0,0,1, 0,1,2,8'h00);
      vt[5]  = mk(0,0,0,0,1, 1,1,2,8'h2D);
      vt[6]  = mk(0,0,0,0,1, 0,1,3,8'h00);
      vt[7]  = mk(0,0,0,0,0, 1,1,3,8'h3C);
      vt[8]  = mk(0,0,0,0,0, 1,1,3,8'h3C);
      vt[9]  = mk(1,0,0,0,0, 1,1,3,8'h3C);
      vt[10] = mk(0,0,0,0,0, 1,1,3,8'h3C);
      vt[11] = mk(0,0,0,0,0, 1,1,3,8'h3C);
      vt[12] = mk(0,0,0,0,0, 1,1,3,8'h3C);
      vt[13] = mk(0,0,0,0,1, 0,1,4,8'h00);
      vt[14] = mk(0,0,0,0,1, 1,1,4,8'h4B);
      vt[15] = mk(0,0,0,0,1, 0,1,5,8'h00);
      vt[16] = mk(0,0,0,0,0, 1,1,5,8'h5A);
      vt[17] = mk(0,1,0,0,0, 1,1,5,8'h5A);
      vt[18] = mk(0,0,0,0,1, 0,0,6,8'h00);
      vt[19] = mk(0,0,1,9,0, 0,0,6,8'h00);
      vt[20] = mk(1,0,0,0,0, 0,1,6,8'h00);
      vt[21] = mk(0,0,0,0,0, 1,1,6,8'h69);

      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_busy",  32'(busy),        32'd0);
      chk("rst_addr",  32'(rom_addr),    32'd0);
      chk("rst_instr", 32'(instr),       32'd0);
      chk("rst_wrap",  32'(wrap),        32'd0);
      rst_n = 1'b1;

      // Sequential run, back-pressure at pc=3, halt while 0x5A waits
      exp_q.push_back(8'h0F); exp_q.push_back(8'h1E); exp_q.push_back(8'h2D);
      exp_q.push_back(8'h3C); exp_q.push_back(8'h4B); exp_q.push_back(8'h5A);
      for (int i = 0; i < 22; i++) begin
         drive(vt[i].start, vt[i].halt, vt[i].jen, vt[i].jaddr, vt[i].rdy);
         @(negedge clk);
         chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vt[i].e_valid));
         chk($sformatf("v%0d_busy", i),  32'(busy),        32'(vt[i].e_busy));
         chk($sformatf("v%0d_addr", i),  32'(rom_addr),    32'(vt[i].e_addr));
         chk($sformatf("v%0d_wrap", i),  32'(wrap),        32'd0);
         if (vt[i].e_valid)
            chk($sformatf("v%0d_instr", i), 32'(instr), 32'(vt[i].e_instr));
      end

      // Jump to 0xC one cycle before the handshake, then run through the wrap
      exp_q.push_back(8'h69); exp_q.push_back(8'hC3); exp_q.push_back(8'hD2);
      exp_q.push_back(8'hE1); exp_q.push_back(8'hF0); exp_q.push_back(8'h0F);
      drive(1'b0, 1'b0, 1'b1, 4'hC, 1'b0);
      @(negedge clk);
      chk("jmp_hold_valid", 32'(instr_valid), 32'd1);
      chk("jmp_hold_addr",  32'(rom_addr),    32'd6);
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
      wrap_cnt  = 0;
      wrap_addr = 4'hF;
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         if (k == 0) chk("jmp_redirect_addr", 32'(rom_addr), 32'hC);
         if (wrap) begin
            wrap_cnt++;
            wrap_addr = rom_addr;
         end
      end
      chk("wrap_count", 32'(wrap_cnt), 32'd1);
      chk("wrap_addr",  32'(wrap_addr), 32'd0);
      instr_ready = 1'b0;
      chk("post_wrap_addr", 32'(rom_addr), 32'd1);
      @(negedge clk);
      chk("pre_rst_valid", 32'(instr_valid), 32'd1);

      // Asynchronous reset in the middle of WAIT, between edges
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(instr_valid), 32'd0);
      chk("arst_addr",  32'(rom_addr),    32'd0);
      chk("arst_busy",  32'(busy),        32'd0);
      drive(1'b1, 1'b0, 1'b1, 4'h7, 1'b0);
      repeat (2) @(negedge clk);
      chk("arst_hold_busy", 32'(busy),     32'd0);
      chk("arst_hold_addr", 32'(rom_addr), 32'd0);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 4'h7, 1'b0);
      @(negedge clk);
      chk("arst_rel_busy", 32'(busy),     32'd0);
      chk("arst_rel_addr", 32'(rom_addr), 32'd0);

      // Jump, halt and handshake all together
      exp_q.push_back(8'h0F);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      @(negedge clk);
      chk("sim_fetch_busy", 32'(busy), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
      @(negedge clk);
      chk("sim_wait_instr", 32'(instr), 32'h0F);
      drive(1'b0, 1'b1, 1'b1, 4'h2, 1'b1);
      @(negedge clk);
      chk("sim_busy",  32'(busy),        32'd0);
      chk("sim_addr",  32'(rom_addr),    32'd2);
      chk("sim_valid", 32'(instr_valid), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
      @(negedge clk);
      chk("sim_idle_addr", 32'(rom_addr), 32'd2);
      exp_q.push_back(8'h2D);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
      @(negedge clk);
      chk("sim_restart_instr", 32'(instr), 32'h2D);
      @(negedge clk);
      chk("sim_no_pend_addr", 32'(rom_addr), 32'd3);
      chk("sim_no_pend_busy", 32'(busy),     32'd1);
      instr_ready = 1'b0;
      repeat (2) @(negedge clk);

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rom_fetch_ctrl.md
Name: rom_fetch_ctrl

Overview:
- Sequential fetch initiator for the asynchronous-read program ROM `M`, which takes a 4-bit address and returns 8-bit data combinationally.
- Owns the program counter and drives `rom_addr`.
- Captures `rom_data` into an instruction register and hands each instruction to the decode stage over a valid/ready handshake.
- Supports a start command, a halt command, and a jump redirect.

Parameters:
- ADDR_W, 4: ROM address width; also the PC width.
- DATA_W, 8: ROM data and instruction width.
- START_ADDR, 0: PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin fetching from the current PC; honoured only in IDLE.
- halt  input  1  stop after the current instruction is consumed.
- jmp_en  input  1  redirect request.
- jmp_addr  input  ADDR_W  redirect target.
- rom_addr  output  ADDR_W  address to the ROM; equals the PC register.
- rom_data  input  DATA_W  ROM read data, valid in the same cycle as rom_addr.
- instr  output  DATA_W  instruction register.
- instr_valid  output  1  instr holds an unconsumed instruction.
- instr_ready  input  1  consumer accepts instr.
- busy  output  1  high when the state is not IDLE.
- wrap  output  1  one-cycle pulse when the PC wraps from all-ones to 0.

Behaviour:
- Reset (async, immediate, mid-operation included):
  - state=IDLE, pc=START_ADDR, instr=0, instr_valid=0, wrap=0.
  - jmp_pend=0, jmp_tgt=0, halt_pend=0.
  - Any in-flight instruction is discarded.
- IDLE:
  - busy=0; rom_addr=pc.
  - start=1 -> FETCH. halt, jmp_en and instr_ready are ignored.
- FETCH (one cycle):
  - rom_addr=pc.
  - At the edge: instr<=rom_data, instr_valid<=1, state<=WAIT.
- WAIT:
  - Holds instr stable while instr_valid=1 and instr_ready=0.
  - Handshake is instr_valid & instr_ready at an edge. On handshake:
    - instr_valid<=0.
    - Next PC priority: jmp_en this cycle -> jmp_addr; else jmp_pend -> jmp_tgt; else pc+1 modulo 2^ADDR_W.
    - jmp_pend<=0.
    - If halt or halt_pend: state<=IDLE, halt_pend<=0. Otherwise state<=FETCH.
- Jump/halt capture:
  - In FETCH, or in WAIT without a handshake, jmp_en=1 sets jmp_pend=1 and jmp_tgt=jmp_addr. The latest request wins.
  - halt=1 in the same states sets halt_pend.
  - A pending jump survives a halt. The PC is redirected at that handshake, so a later start fetches from the jump target.
- wrap:
  - Pulses high for one cycle, the cycle after a handshake in which the sequential increment took pc from 2^ADDR_W-1 to 0.
  - A jump to 0 does not pulse wrap.
- Latency:
  - start sampled at edge k -> FETCH during cycle k+1 -> instr_valid=1 from cycle k+2.
  - Peak throughput: one instruction per 2 cycles, with instr_ready held high.
- Simultaneous events:
  - start while busy is ignored.
  - jmp_en together with handshake uses jmp_addr directly and leaves no pending jump.
  - halt together with handshake finishes in IDLE with pc already advanced.
- Widths: all PC arithmetic is unsigned ADDR_W-bit, with the carry discarded.

Test Plan:
The bench ROM model returns rom_data={addr, ~addr}, so 0x0 -> 8'h0F and 0xC -> 8'hC3.
- Reset then start pulse, instr_ready=1 -> instr sequence 8'h0F, 8'h1E, 8'h2D, …; instr_valid first high 2 cycles after the start edge; a new instruction every 2 cycles.
- Back-pressure: instr_ready=0 for 5 cycles at pc=3 -> instr held at 8'h3C with instr_valid=1 and rom_addr=3; after ready rises, the next instruction is 8'h4B.
- Jump: jmp_en with jmp_addr=4'hC one cycle before the handshake -> next instrs 8'hC3, 8'hD2, 8'hE1, 8'hF0, 8'h0F; wrap pulses once after the 0xF handshake.
- Halt: halt pulsed while instr 8'h5A waits -> after its handshake busy=0 and rom_addr=6; a later start yields 8'h69.
- Async reset: assert rst_n=0 mid-WAIT between edges -> instr_valid=0, rom_addr=0 and busy=0 immediately; jmp_en/start stay ignored until rst_n rises and start is pulsed.
- Simultaneity: jmp_en (jmp_addr=4'h2) together with handshake and halt -> state IDLE, rom_addr=2, no pending jump; start -> 8'h2D.
